// File: rtl/hls_channel_pkg.sv
// Shared constants for HLS channel ports: default data width and the
// handshake signal suffixes the kernel generator appends to channel names.
package hls_channel_pkg;

    localparam int unsigned CHANNEL_WIDTH_DEFAULT = 32;

    localparam string SUFFIX_WRITE_VALID = "_write_valid";
    localparam string SUFFIX_WRITE_READY = "_write_ready";
    localparam string SUFFIX_IN_DATA     = "_in_data";
    localparam string SUFFIX_READ_VALID  = "_read_valid";
    localparam string SUFFIX_READ_READY  = "_read_ready";
    localparam string SUFFIX_OUT_DATA    = "_out_data";

endpackage

// File: rtl/hls_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one registered
// read port (raddr/ren sampled, rdata valid next cycle and held otherwise).
module hls_fifo_mem #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hls_channel_fifo.sv
// Buffered HLS channel between a producer and a consumer kernel: count-based
// synchronous FIFO with registered pop data and sticky misuse flags.
module hls_channel_fifo
    import hls_channel_pkg::*;
#(
    parameter  int unsigned WIDTH  = CHANNEL_WIDTH_DEFAULT,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              write_valid,
    output logic              write_ready,
    input  logic              read_valid,
    output logic              read_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              push_fire;
    logic              pop_fire;

    // Ready flags depend only on registered occupancy.
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign write_ready = ~full;
    assign read_ready  = ~empty;

    assign push_fire = write_valid & ~full;
    assign pop_fire  = read_valid & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (write_valid && full) begin
                overflow <= 1'b1;
            end
            if (read_valid && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    hls_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wen   (push_fire),
        .waddr (wr_ptr),
        .wdata (in_data),
        .ren   (pop_fire),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule
